// File: rtl/stump_control_ws.sv
// Multi-cycle Stump control unit with memory wait states and internal branch evaluation.
// Optional performance counters are enabled by defining STUMP_CTRL_PERF_EN.
module stump_control_ws #(
  parameter int MEM_WAIT = 0
`ifdef STUMP_CTRL_PERF_EN
  ,
  parameter int CNT_W    = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic [3:0]  cc,
  input  logic        mem_ready,
  output logic        fetch,
  output logic        execute,
  output logic        memory,
  output logic        ir_en,
  output logic        ext_op,
  output logic        reg_write,
  output logic [2:0]  dest,
  output logic [2:0]  srcA,
  output logic [2:0]  srcB,
  output logic [1:0]  shift_op,
  output logic        opB_mux_sel,
  output logic [2:0]  alu_func,
  output logic        cc_en,
  output logic        mem_ren,
  output logic        mem_wen
`ifdef STUMP_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count
`endif
);

  typedef enum logic [1:0] {S_RST, FETCH, EXECUTE, MEMORY} state_t;

  localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       done;
  logic       taken;

  logic [2:0] op;
  logic       s_bit;
  logic       t_bit;
  logic [2:0] rd;
  logic [2:0] ra;
  logic [2:0] rb;
  logic [1:0] sh;
  logic [3:0] cond;

  assign op    = ir[15:13];
  assign s_bit = ir[12];
  assign t_bit = ir[11];
  assign rd    = ir[10:8];
  assign ra    = ir[7:5];
  assign rb    = ir[4:2];
  assign sh    = ir[1:0];
  assign cond  = ir[11:8];

  assign done = (wait_cnt == WAIT_MAX) && mem_ready;

  // The wait counter restarts whenever an access state is entered and holds at MEM_WAIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_RST;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_RST: begin
          state    <= FETCH;
          wait_cnt <= '0;
        end
        FETCH: begin
          if (done) state <= EXECUTE;
          else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 4'd1;
        end
        EXECUTE: begin
          wait_cnt <= '0;
          state    <= (op == 3'd6) ? MEMORY : FETCH;
        end
        MEMORY: begin
          if (done) begin
            state    <= FETCH;
            wait_cnt <= '0;
          end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: begin
          state    <= S_RST;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    taken = 1'b0;
    case (cond)
      4'h0: taken = 1'b1;
      4'h1: taken = 1'b0;
      4'h2: taken = !cc[0] && !cc[2];
      4'h3: taken = cc[0] || cc[2];
      4'h4: taken = !cc[0];
      4'h5: taken = cc[0];
      4'h6: taken = !cc[2];
      4'h7: taken = cc[2];
      4'h8: taken = !cc[1];
      4'h9: taken = cc[1];
      4'hA: taken = !cc[3];
      4'hB: taken = cc[3];
      4'hC: taken = (cc[3] == cc[1]);
      4'hD: taken = (cc[3] != cc[1]);
      4'hE: taken = !cc[2] && (cc[3] == cc[1]);
      4'hF: taken = cc[2] || (cc[3] != cc[1]);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    fetch       = (state == FETCH);
    execute     = (state == EXECUTE);
    memory      = (state == MEMORY);
    ir_en       = 1'b0;
    ext_op      = 1'b0;
    reg_write   = 1'b0;
    dest        = 3'd0;
    srcA        = 3'd0;
    srcB        = 3'd0;
    shift_op    = 2'd0;
    opB_mux_sel = 1'b0;
    alu_func    = 3'd0;
    cc_en       = 1'b0;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    case (state)
      FETCH: begin
        mem_ren = 1'b1;
        srcA    = 3'd7;
        if (done) begin
          ir_en     = 1'b1;
          reg_write = 1'b1;
          dest      = 3'd7;
        end
      end
      EXECUTE: begin
        if (op == 3'd7) begin
          srcA        = 3'd7;
          opB_mux_sel = 1'b1;
          ext_op      = 1'b1;
          dest        = 3'd7;
          reg_write   = taken;
        end else begin
          srcA = ra;
          if (t_bit) begin
            opB_mux_sel = 1'b1;
          end else begin
            srcB     = rb;
            shift_op = sh;
          end
          // op 6 only forms the LD/ST address, so it writes neither a register nor flags.
          if (op != 3'd6) begin
            alu_func  = op;
            dest      = rd;
            reg_write = 1'b1;
            cc_en     = s_bit;
          end
        end
      end
      MEMORY: begin
        if (s_bit) begin
          mem_wen = 1'b1;
          srcB    = rd;
        end else begin
          mem_ren = 1'b1;
          if (done) begin
            reg_write = 1'b1;
            dest      = rd;
          end
        end
      end
      default: ;
    endcase
  end

`ifdef STUMP_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_count <= '0;
      stall_count <= '0;
    end else begin
      if (((state == EXECUTE) && (op != 3'd6)) || ((state == MEMORY) && done))
        instr_count <= instr_count + 1'b1;
      if (((state == FETCH) || (state == MEMORY)) && !done)
        stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stump_control_ws.sv
// Randomized self-checking bench for stump_control_ws: two instances (MEM_WAIT 0 and 2)
// checked cycle by cycle against an instruction-level reference model.
module tb_stump_control_ws;

  logic clk;
  logic rst;
  logic [15:0] ir_v  [2];
  logic [3:0]  cc_v  [2];
  logic        rdy_v [2];
  logic [1:0][23:0] outs;
  logic [1:0][15:0] ic_v;
  logic [1:0][15:0] sc_v;

  int tests = 0;
  int fails = 0;
  int instr_m [2];
  int stall_m [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic fetch, execute, memory, ir_en, ext_op, reg_write;
    logic [2:0] dest, srcA, srcB, alu_func;
    logic [1:0] shift_op;
    logic opB_mux_sel, cc_en, mem_ren, mem_wen;
`ifdef STUMP_CTRL_PERF_EN
    logic [15:0] instr_count, stall_count;
    assign ic_v[g] = instr_count;
    assign sc_v[g] = stall_count;
`else
    assign ic_v[g] = 16'd0;
    assign sc_v[g] = 16'd0;
`endif
    stump_control_ws #(.MEM_WAIT(g * 2)) dut (
      .clk(clk), .rst(rst), .ir(ir_v[g]), .cc(cc_v[g]), .mem_ready(rdy_v[g]),
      .fetch(fetch), .execute(execute), .memory(memory), .ir_en(ir_en),
      .ext_op(ext_op), .reg_write(reg_write), .dest(dest), .srcA(srcA), .srcB(srcB),
      .shift_op(shift_op), .opB_mux_sel(opB_mux_sel), .alu_func(alu_func),
      .cc_en(cc_en), .mem_ren(mem_ren), .mem_wen(mem_wen)
`ifdef STUMP_CTRL_PERF_EN
      , .instr_count(instr_count), .stall_count(stall_count)
`endif
    );
    assign outs[g] = {fetch, execute, memory, ir_en, ext_op, reg_write, dest, srcA, srcB,
                      shift_op, opB_mux_sel, alu_func, cc_en, mem_ren, mem_wen};
  end

  function automatic int mw(input int d);
    return d * 2;
  endfunction

  // Condition table: odd codes are the negation of the preceding even code.
  function automatic bit branchTaken(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, v, c, base;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (cond[3:1])
      3'd0: base = 1'b1;
      3'd1: base = !c && !z;
      3'd2: base = !c;
      3'd3: base = !z;
      3'd4: base = !v;
      3'd5: base = !n;
      3'd6: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return base ^ cond[0];
  endfunction

  // ph: 0 reset, 1 fetch, 2 execute, 3 memory.
  function automatic logic [23:0] model(input int ph, input logic [15:0] i,
                                        input logic [3:0] f, input bit done);
    logic fe, ex, me, ie, ext, rw, opb, cce, ren, wen;
    logic [2:0] dst, sa, sb, alu;
    logic [1:0] shf;
    int op;
    {fe, ex, me, ie, ext, rw, opb, cce, ren, wen} = '0;
    dst = 0; sa = 0; sb = 0; alu = 0; shf = 0;
    op = int'(i[15:13]);
    if (ph == 1) begin
      fe = 1; ren = 1; sa = 7;
      if (done) begin ie = 1; rw = 1; dst = 7; end
    end else if (ph == 2) begin
      ex = 1;
      if (op == 7) begin
        sa = 7; opb = 1; ext = 1; dst = 7; rw = branchTaken(i[11:8], f);
      end else begin
        sa = i[7:5];
        if (i[11]) opb = 1;
        else begin sb = i[4:2]; shf = i[1:0]; end
        if (op < 6) begin alu = 3'(op); dst = i[10:8]; rw = 1; cce = i[12]; end
      end
    end else if (ph == 3) begin
      me = 1;
      if (i[12]) begin wen = 1; sb = i[10:8]; end
      else begin
        ren = 1;
        if (done) begin rw = 1; dst = i[10:8]; end
      end
    end
    return {fe, ex, me, ie, ext, rw, dst, sa, sb, shf, opb, alu, cce, ren, wen};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic stepCycle(input int d, input int ph, input bit done, input string tag);
    @(negedge clk);
    checkOutput(tag, 32'(outs[d]), 32'(model(ph, ir_v[d], cc_v[d], done)));
    if (!rst) begin
      instr_m[d] = 0;
      stall_m[d] = 0;
    end else begin
      if ((ph == 1 || ph == 3) && !done) stall_m[d]++;
      if ((ph == 2 && ir_v[d][15:13] != 3'd6) || (ph == 3 && done)) instr_m[d]++;
    end
    @(posedge clk);
    #1;
  endtask

  // low < 0: random ready; otherwise ready is held low for the first 'low' cycles.
  task automatic doAccess(input int d, input int ph, input int low, input string tag);
    bit rdy, done;
    for (int k = 0; k < 40; k++) begin
      rdy = (low < 0) ? ($urandom_range(0, 2) != 0) : (k >= low);
      done = (k >= mw(d)) && rdy;
      rdy_v[d] = rdy;
      stepCycle(d, ph, done, tag);
      if (done) return;
    end
    tests++;
    fails++;
    $display("[TB] FAIL %s: access did not complete within 40 cycles", tag);
  endtask

  task automatic checkPerf(input int d, input string tag);
`ifdef STUMP_CTRL_PERF_EN
    checkOutput({tag, " instr_count"}, 32'(ic_v[d]), 32'(instr_m[d][15:0]));
    checkOutput({tag, " stall_count"}, 32'(sc_v[d]), 32'(stall_m[d][15:0]));
`else
    if (tag.len() < 0) $display("[TB] %s", tag);
`endif
  endtask

  task automatic applyStimulus(input int d, input logic [15:0] i, input logic [3:0] f,
                               input int low, input string tag);
    ir_v[d] = i;
    cc_v[d] = f;
    doAccess(d, 1, low, {tag, " F"});
    rdy_v[d] = 1'($urandom_range(0, 1));
    stepCycle(d, 2, 1'b0, {tag, " E"});
    if (i[15:13] == 3'd6) doAccess(d, 3, low, {tag, " M"});
  endtask

  task automatic resetAll();
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      ir_v[0] = 16'($urandom); ir_v[1] = 16'($urandom);
      stepCycle(0, 0, 1'b0, "reset low");
      @(negedge clk);
      checkOutput("reset low dut2", 32'(outs[1]), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    stepCycle(0, 0, 1'b0, "reset release");
    instr_m[0] = 0; stall_m[0] = 0;
    instr_m[1] = 0; stall_m[1] = 0;
  endtask

  task automatic midMemoryReset(input int d);
    ir_v[d] = 16'hD000;
    cc_v[d] = 4'h0;
    doAccess(d, 1, 0, "midrst F");
    stepCycle(d, 2, 1'b0, "midrst E");
    rdy_v[d] = 1'b0;
    stepCycle(d, 3, 1'b0, "midrst M1");
    rst = 1'b0;
    stepCycle(d, 3, 1'b0, "midrst M2");
    rst = 1'b1;
    stepCycle(d, 0, 1'b0, "midrst S_RST");
    instr_m[d] = 0;
    stall_m[d] = 0;
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ir_v[d] = 16'h0; cc_v[d] = 4'h0; rdy_v[d] = 1'b1;
      instr_m[d] = 0; stall_m[d] = 0;
    end

    // MEM_WAIT = 0 instance
    resetAll();
    applyStimulus(0, 16'h1000, 4'h0, 0, "alu add");
    applyStimulus(0, 16'h2B45, 4'h0, 2, "alu imm");
    applyStimulus(0, 16'h0A1F, 4'h0, 0, "alu reg");
`ifdef STUMP_CTRL_PERF_EN
    checkOutput("perf instr=3", 32'(ic_v[0]), 32'd3);
    checkOutput("perf stall=2", 32'(sc_v[0]), 32'd2);
`endif
    applyStimulus(0, 16'hC000, 4'h0, 0, "load");
    applyStimulus(0, 16'hD000, 4'h0, 0, "store");
    applyStimulus(0, 16'hE700, 4'b0100, 0, "beq taken");
    applyStimulus(0, 16'hE700, 4'b0000, 0, "beq not taken");
    for (int c = 0; c < 16; c++)
      applyStimulus(0, {4'hE, 4'(c), 8'h00}, 4'($urandom), 0, "branch cond");
    for (int n = 0; n < 60; n++)
      applyStimulus(0, 16'($urandom), 4'($urandom), -1, "random mw0");
    checkPerf(0, "mw0");

    // MEM_WAIT = 2 instance
    resetAll();
    applyStimulus(1, 16'h1000, 4'h0, 4, "wait fetch");
    applyStimulus(1, 16'hC3E0, 4'h0, 1, "wait load");
    applyStimulus(1, 16'hD5A0, 4'h0, 3, "wait store");
    for (int n = 0; n < 60; n++)
      applyStimulus(1, 16'($urandom), 4'($urandom), -1, "random mw2");
    checkPerf(1, "mw2");
    midMemoryReset(1);
    for (int n = 0; n < 10; n++)
      applyStimulus(1, 16'($urandom), 4'($urandom), -1, "after midrst");
    checkPerf(1, "after midrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
